// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared processor constants for the fetch/decode boundary
//
// Purpose: constants shared by the fetch stage and the decode/control unit.
//   PC_STEP     byte increment between sequential instructions
//   OPCODE_MSB  top bit of the opcode field that drives decode
//   OPCODE_LSB  bottom bit of the opcode field
//   NOP_INSTR   all-zero word (opcode 000000) used as a decode-side bubble
//   opcode_of   extracts the opcode field from an instruction word
package fetch_stage_pkg;

    localparam int          PC_STEP    = 4;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 26;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous buffer of fetched {pc, instr} words
//
// Purpose: holds words returned by instruction memory until decode consumes them.
// Ports:
//   clk          in   clock, all updates on rising edge
//   rst          in   synchronous active-high reset (empties the buffer)
//   i_flush      in   discard all entries; wins over push and pop
//   i_push       in   write i_push_data at the tail
//   i_push_data  in   {pc, instr} entry
//   i_pop        in   advance the head
//   o_head       out  head entry (stale contents when o_count == 0)
//   o_count      out  number of valid entries, 0..DEPTH
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_clear;
    logic             w_full;

    assign w_clear = rst | i_flush;
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // Storage carries no reset; the head is qualified by o_count downstream.
    always_ff @(posedge clk) begin
        if (!w_clear && i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // The upstream issue rule reserves a slot for every outstanding read.
    always_ff @(posedge clk) begin
        if (!w_clear) begin
            assert (!(i_push && w_full));
            assert (!(i_pop && (r_count == '0)));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, read issue, in-flight tracking, redirect
//
// Purpose: owns the PC, issues sequential reads to a 1-cycle synchronous
// instruction memory and buffers returned words so decode stalls never drop
// an in-flight fetch. A taken branch from EXE redirects the PC and discards
// wrong-path words.
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   freeze        in   decode stalled; head not consumed
//   branch_taken  in   redirect pulse; flushes the stage
//   branch_addr   in   redirect target
//   imem_addr     out  read address (current PC)
//   imem_rd_en    out  read request; data returns next cycle
//   imem_rdata    in   data for the previous cycle's request
//   if_valid      out  if_instr/if_pc hold a valid instruction
//   if_instr      out  head instruction (0 when not valid)
//   if_pc         out  address of if_instr (0 when not valid)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam int ENT_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  r_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;

    logic [CNT_W-1:0]   w_count;
    logic [ENT_W-1:0]   w_head;
    logic               w_valid;
    logic               w_pop;
    logic               w_issue;
    logic [OCC_W-1:0]   w_occupancy;

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid & ~freeze & ~branch_taken;

    // Entries that will be held after this edge, counting the word already
    // on its way back. A new read is only issued if it is guaranteed a slot.
    assign w_occupancy = OCC_W'(w_count) - OCC_W'(w_pop) + OCC_W'(r_inflight);
    assign w_issue     = ~rst & ~branch_taken & (w_occupancy < OCC_W'(DEPTH));

    assign imem_addr  = r_pc;
    assign imem_rd_en = w_issue;

    // Reset beats redirect, redirect beats sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            if (branch_taken) begin
                r_pc <= branch_addr;
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(PC_STEP);
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
        end
    end

    // A word returning during a redirect cycle is wrong-path; the flush
    // input of the buffer overrides the push.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (branch_taken),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_pc, imem_rdata}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign if_valid = w_valid;
    assign if_instr = w_valid ? w_head[INSTR_W-1:0]     : '0;
    assign if_pc    = w_valid ? w_head[ENT_W-1:INSTR_W] : '0;

endmodule
